// File: rtl/min_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : min_scan_pkg
//  Description : Shared types and helpers for the two-minimum scan sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package min_scan_pkg;

    // Sequencer states; width fixed so the encoding is explicit.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Largest sample value at the default 4-bit sample width.
    localparam int N_MAX_VAL = 15;

    // All-ones pattern of the requested width (up to 32 bits).
    function automatic logic [31:0] all_ones(input int width);
        if (width >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/min2_update.sv
`default_nettype none
// ============================================================================
//  Module      : min2_update
//  Description : Combinational two-minimum update for one incoming sample.
//  Revision    : 1.0  initial release
// ============================================================================
module min2_update #(
    parameter int N  = 4,
    parameter int IW = 4
) (
    input  logic [N-1:0]  i_x,
    input  logic [N-1:0]  i_w1,
    input  logic [N-1:0]  i_w2,
    input  logic [IW-1:0] i_wi,
    input  logic [IW-1:0] i_cnt,
    output logic [N-1:0]  o_w1,
    output logic [N-1:0]  o_w2,
    output logic [IW-1:0] o_wi
);

    // Strict compares: an equal later value never displaces the earlier
    // minimum, so it falls through to become the second minimum instead.
    always_comb begin
        o_w1 = i_w1;
        o_w2 = i_w2;
        o_wi = i_wi;
        if (i_x < i_w1) begin
            o_w2 = i_w1;
            o_w1 = i_x;
            o_wi = i_cnt;
        end else if (i_x < i_w2) begin
            o_w2 = i_x;
        end
    end

endmodule
`default_nettype wire

// File: rtl/min_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : min_scan_ctrl
//  Description : Frame sequencer for the two-minimum search. Accepts M samples
//                over valid/ready, then publishes min1/min2/index with a
//                one-cycle done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module min_scan_ctrl
    import min_scan_pkg::*;
#(
    parameter int N  = 4,
    parameter int M  = 10,
    parameter int IW = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic [N-1:0]  data_i,
    input  logic          data_valid_i,
    output logic          data_ready_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [N-1:0]  min1_o,
    output logic [N-1:0]  min2_o,
    output logic [IW-1:0] index_o
);

    localparam logic [N-1:0]  c_ones = N'(all_ones(N));
    localparam logic [IW-1:0] c_last = IW'(M - 1);

    state_t        r_state;
    logic [N-1:0]  r_w1;
    logic [N-1:0]  r_w2;
    logic [IW-1:0] r_wi;
    logic [IW-1:0] r_cnt;

    logic          w_accept;
    logic          w_last;
    logic [N-1:0]  w_w1_next;
    logic [N-1:0]  w_w2_next;
    logic [IW-1:0] w_wi_next;

    // data_ready_o is registered and high exactly while in SCAN.
    assign w_accept = data_valid_i & data_ready_o;
    assign w_last   = (r_cnt == c_last);

    min2_update #(
        .N  (N),
        .IW (IW)
    ) u_min2_update (
        .i_x   (data_i),
        .i_w1  (r_w1),
        .i_w2  (r_w2),
        .i_wi  (r_wi),
        .i_cnt (r_cnt),
        .o_w1  (w_w1_next),
        .o_w2  (w_w2_next),
        .o_wi  (w_wi_next)
    );

    // Sequencer, working registers and registered result/status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_w1         <= c_ones;
            r_w2         <= c_ones;
            r_wi         <= '0;
            r_cnt        <= '0;
            data_ready_o <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            min1_o       <= c_ones;
            min2_o       <= c_ones;
            index_o      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        r_state      <= SCAN;
                        r_w1         <= c_ones;
                        r_w2         <= c_ones;
                        r_wi         <= '0;
                        r_cnt        <= '0;
                        data_ready_o <= 1'b1;
                        busy_o       <= 1'b1;
                    end
                end
                SCAN: begin
                    // Abort wins over the final-sample transition; any
                    // sample accepted alongside it is dropped.
                    if (abort_i) begin
                        r_state      <= IDLE;
                        data_ready_o <= 1'b0;
                        busy_o       <= 1'b0;
                    end else if (w_accept) begin
                        r_w1 <= w_w1_next;
                        r_w2 <= w_w2_next;
                        r_wi <= w_wi_next;
                        if (w_last) begin
                            // Counter is held on the last sample so it never
                            // wraps within a frame.
                            r_state      <= DONE;
                            data_ready_o <= 1'b0;
                            done_o       <= 1'b1;
                            min1_o       <= w_w1_next;
                            min2_o       <= w_w2_next;
                            index_o      <= w_wi_next;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    done_o  <= 1'b0;
                    busy_o  <= 1'b0;
                end
                default: begin
                    r_state      <= IDLE;
                    data_ready_o <= 1'b0;
                    busy_o       <= 1'b0;
                    done_o       <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_min_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_min_scan_ctrl
//  Description : Self-checking bench for min_scan_ctrl with a queue-based
//                frame model, directed vector table and random traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_min_scan_ctrl;

    localparam int N  = 4;
    localparam int M  = 10;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [N-1:0]  data_i = '0;
    logic          data_valid_i = 1'b0;
    logic          data_ready_o;
    logic          busy_o;
    logic          done_o;
    logic [N-1:0]  min1_o;
    logic [N-1:0]  min2_o;
    logic [IW-1:0] index_o;

    int checks   = 0;
    int failures = 0;

    min_scan_ctrl #(.N(N), .M(M), .IW(IW)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .data_ready_o (data_ready_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .min1_o       (min1_o),
        .min2_o       (min2_o),
        .index_o      (index_o)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (frame level) ----------------
    int            m_phase = 0;     // 0 idle, 1 collecting, 2 reporting
    logic [N-1:0]  q[$];
    logic [N-1:0]  e_min1 = 4'hF;
    logic [N-1:0]  e_min2 = 4'hF;
    logic [IW-1:0] e_idx  = '0;
    logic          prev_done = 1'b0;
    int            busy_cnt = 0;
    int            done_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Result of a finished frame: smallest, second smallest of the multiset,
    // and first position of the smallest.
    task automatic compute_result();
        logic [N-1:0] s[$];
        s = q;
        s.sort();
        e_min1 = s[0];
        e_min2 = s[1];
        for (int j = M - 1; j >= 0; j--) begin
            if (q[j] == e_min1) e_idx = IW'(j);
        end
    endtask

    // One clock: advance model from current inputs, then compare after edge.
    task automatic cycle();
        int nphase;
        nphase = m_phase;
        if (rst_i) begin
            nphase = 0;
            e_min1 = 4'hF;
            e_min2 = 4'hF;
            e_idx  = '0;
            q.delete();
        end else begin
            case (m_phase)
                0: if (start_i) begin
                       nphase = 1;
                       q.delete();
                   end
                1: if (abort_i) begin
                       nphase = 0;
                   end else if (data_valid_i) begin
                       q.push_back(data_i);
                       if (q.size() == M) begin
                           compute_result();
                           nphase = 2;
                       end
                   end
                default: nphase = 0;
            endcase
        end
        @(posedge clk);
        m_phase = nphase;
        #1;
        chk("data_ready", int'(data_ready_o), int'(m_phase == 1));
        chk("busy",       int'(busy_o),       int'(m_phase != 0));
        chk("done",       int'(done_o),       int'(m_phase == 2));
        chk("min1",       int'(min1_o),       int'(e_min1));
        chk("min2",       int'(min2_o),       int'(e_min2));
        chk("index",      int'(index_o),      int'(e_idx));
        chk("double_done", int'(done_o && prev_done), 0);
        prev_done = done_o;
        if (busy_o) busy_cnt++;
        if (done_o) done_cnt++;
    endtask

    // Start one frame, feed samples with 'gap' idle cycles before each, and
    // optionally pulse start during SCAN and in the DONE cycle.
    task automatic run_frame(input logic [9:0][3:0] s, input int gap,
                             input bit pulse_scan, input bit pulse_done);
        start_i = 1'b1;
        cycle();
        start_i = 1'b0;
        for (int i = 0; i < M; i++) begin
            for (int g = 0; g < gap; g++) begin
                data_valid_i = 1'b0;
                cycle();
            end
            data_valid_i = 1'b1;
            data_i = s[i];
            start_i = (pulse_scan && i == 3);
            cycle();
            start_i = 1'b0;
        end
        data_valid_i = 1'b0;
        start_i = pulse_done;
        cycle();
        start_i = 1'b0;
    endtask

    typedef struct {
        logic [9:0][3:0] s;
        int              gap;
        logic [3:0]      e1;
        logic [3:0]      e2;
        logic [3:0]      ei;
    } vec_t;

    vec_t vt[5];

    initial begin
        // frame {7,3,9,3,1,8,2,5,6,4} written index 9 first
        vt[0] = '{s: {4'd4,4'd6,4'd5,4'd2,4'd8,4'd1,4'd3,4'd9,4'd3,4'd7}, gap: 0, e1: 4'd1,  e2: 4'd2,  ei: 4'd4};
        vt[1] = '{s: {4'd9,4'd9,4'd9,4'd9,4'd9,4'd9,4'd5,4'd9,4'd5,4'd9}, gap: 0, e1: 4'd5,  e2: 4'd5,  ei: 4'd1};
        vt[2] = '{s: {10{4'd15}},                                          gap: 0, e1: 4'd15, e2: 4'd15, ei: 4'd0};
        vt[3] = '{s: {4'd4,4'd6,4'd5,4'd2,4'd8,4'd1,4'd3,4'd9,4'd3,4'd7}, gap: 1, e1: 4'd1,  e2: 4'd2,  ei: 4'd4};
        vt[4] = '{s: {4'd0,4'd8,4'd8,4'd8,4'd8,4'd8,4'd8,4'd8,4'd8,4'd8}, gap: 0, e1: 4'd0,  e2: 4'd8,  ei: 4'd9};

        // reset state
        rst_i = 1'b1;
        cycle();
        cycle();
        rst_i = 1'b0;
        cycle();

        // directed vector table
        for (int v = 0; v < 5; v++) begin
            busy_cnt = 0;
            done_cnt = 0;
            run_frame(vt[v].s, vt[v].gap, 1'b0, 1'b0);
            chk("tbl_min1",  int'(min1_o),  int'(vt[v].e1));
            chk("tbl_min2",  int'(min2_o),  int'(vt[v].e2));
            chk("tbl_index", int'(index_o), int'(vt[v].ei));
            chk("tbl_busy_cycles", busy_cnt, 11 + 10 * vt[v].gap);
            chk("tbl_done_count",  done_cnt, 1);
        end

        // abort: frame A completes, frame B aborted after 4 samples
        run_frame(vt[0].s, 0, 1'b0, 1'b0);
        done_cnt = 0;
        start_i = 1'b1;
        cycle();
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data_valid_i = 1'b1;
            data_i = 4'd0;
            cycle();
        end
        abort_i = 1'b1;
        data_i = 4'd0;
        cycle();
        abort_i = 1'b0;
        data_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        chk("abort_no_done", done_cnt, 0);
        chk("abort_keep_min1", int'(min1_o), 1);
        chk("abort_ready_low", int'(data_ready_o), 0);
        run_frame(vt[1].s, 0, 1'b0, 1'b0);
        chk("after_abort_min1", int'(min1_o), 5);

        // start pulses during SCAN and DONE are ignored
        done_cnt = 0;
        run_frame(vt[4].s, 0, 1'b1, 1'b1);
        cycle();
        chk("ignored_start_done_cnt", done_cnt, 1);
        chk("ignored_start_busy", int'(busy_o), 0);
        // start in the cycle right after done is honoured
        run_frame(vt[0].s, 0, 1'b0, 1'b0);
        run_frame(vt[1].s, 0, 1'b0, 1'b0);
        chk("back_to_back_min1", int'(min1_o), 5);
        chk("back_to_back_done_cnt", done_cnt, 3);

        // reset at sample 6 of a frame
        start_i = 1'b1;
        cycle();
        start_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            data_valid_i = 1'b1;
            data_i = vt[0].s[i];
            cycle();
        end
        rst_i = 1'b1;
        data_i = vt[0].s[6];
        cycle();
        rst_i = 1'b0;
        data_valid_i = 1'b0;
        chk("rst_min1",  int'(min1_o),  15);
        chk("rst_index", int'(index_o), 0);
        chk("rst_busy",  int'(busy_o),  0);
        cycle();
        run_frame(vt[0].s, 0, 1'b0, 1'b0);
        chk("post_rst_min1",  int'(min1_o),  1);
        chk("post_rst_index", int'(index_o), 4);

        // random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            start_i      = ($urandom_range(0, 7) == 0);
            abort_i      = ($urandom_range(0, 59) == 0);
            rst_i        = ($urandom_range(0, 299) == 0);
            data_valid_i = ($urandom_range(0, 9) < 7);
            data_i       = N'($urandom_range(0, (c % 3 == 0) ? 3 : 15));
            cycle();
        end
        rst_i = 1'b0;
        abort_i = 1'b0;
        start_i = 1'b0;
        data_valid_i = 1'b0;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
